micro_sequencer: RTL and testbench

//  Multi-cycle microcoded control sequencer for the RV32I pipeline plus custom ops. Sits between fetch/decode and ID/EX register.

---
 rtl/micro_sequencer_if.sv | 22 ++
 rtl/micro_sequencer.sv | 135 +++++++++++++
 tb/tb_micro_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: instruction handshake and control-word bus of the micro_sequencer.
interface micro_sequencer_if #(
    parameter int OPCODE_LENGTH = 7,
    parameter int FUNCT3_LENGTH = 3,
    parameter int FUNCT7_LENGTH = 7,
    parameter int LEN_WIDTH = 8
);
    logic in_valid, in_ready, stall, ctrl_valid, uop_last, busy, illegal;
    logic [OPCODE_LENGTH-1:0] opcode;
    logic [FUNCT3_LENGTH-1:0] funct3;
    logic [FUNCT7_LENGTH-1:0] funct7;
    logic [LEN_WIDTH-1:0] copy_len, uop_index;
    logic [15:0] ctrl_word;
    modport master (
        output in_valid, opcode, funct3, funct7, copy_len, stall,
        input in_ready, ctrl_valid, ctrl_word, uop_last, uop_index, busy, illegal
    );
    modport slave (
        input in_valid, opcode, funct3, funct7, copy_len, stall,
        output in_ready, ctrl_valid, ctrl_word, uop_last, uop_index, busy, illegal
    );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: expands decoded instructions into registered 16-bit control words, with MUL/MEMCOPY micro-routines.
// Optional ILLEGAL_TRAP_EN flags unmatched encodings and holds off fetch for one extra cycle.
module micro_sequencer #(
    parameter int OPCODE_LENGTH = 7,
    parameter int FUNCT3_LENGTH = 3,
    parameter int FUNCT7_LENGTH = 7,
    parameter int MUL_CYCLES = 4,
    parameter int LEN_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    micro_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, MUL, CPY_RD, CPY_WR, TRAP} state_t;
    localparam logic [OPCODE_LENGTH-1:0] MUL_OP = 7'b0111111;
    localparam logic [OPCODE_LENGTH-1:0] CPY_OP = 7'b1111111;
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] MUL_LAST = LEN_WIDTH'(MUL_CYCLES - 1);

    // Every legal single-cycle word is nonzero, so a zero result doubles as "unmatched".
    function automatic logic [15:0] decode(input logic [OPCODE_LENGTH-1:0] op,
                                           input logic [FUNCT3_LENGTH-1:0] f3,
                                           input logic [FUNCT7_LENGTH-1:0] f7);
        logic [3:0] base;
        logic alt_s, alt_r;
        base = f3 == 3'd0 ? 4'd0 : f3 == 3'd6 ? 4'd8 : f3 == 3'd7 ? 4'd9 : {1'b0, f3} + 4'd1;
        alt_s = f3 == 3'd5 && f7 == 7'h20;
        alt_r = alt_s || (f3 == 3'd0 && f7 == 7'h20);
        case (op)
            7'b0110011: decode = f7 == 7'h00 || alt_r ? {7'b1000000, base + {3'b0, alt_r}, 5'b0} : 16'h0;
            7'b0010011: decode = f3 != 3'd5 || f7 == 7'h00 || alt_s ? {7'b1100000, base + {3'b0, alt_s}, 5'b0} : 16'h0;
            7'b1100111: decode = f3 == 3'd0 ? 16'hC400 : 16'h0;
            7'b0000011: decode = f3 != 3'd3 && f3 < 3'd6 ? {13'h1E00, f3[2] ? f3 : f3 + 3'd1} : 16'h0;
            7'b0100011: decode = f3 < 3'd3 ? {13'h0900, f3 + 3'd1} : 16'h0;
            7'b1100011: decode = f3[2:1] == 2'b01 ? 16'h0 :
                                 {7'b0000001, f3[2] ? (f3[1] ? 4'd4 : 4'd3) : 4'd1, f3[2], f3[0], 3'b0};
            default: decode = 16'h0;
        endcase
    endfunction

    state_t state_q, state_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d, len_q, len_d;
    logic [15:0] word_q, word_d, dec;
    logic valid_q, valid_d, last_q, last_d, illegal_q, illegal_d, accept;

    assign bus.in_ready = !bus.stall && (state_q == IDLE || state_q == ISSUE);
    assign accept = bus.in_valid && bus.in_ready;
    assign dec = decode(bus.opcode, bus.funct3, bus.funct7);
    assign bus.ctrl_valid = valid_q;
    assign bus.ctrl_word = word_q;
    assign bus.uop_last = last_q;
    assign bus.uop_index = idx_q;
    assign bus.illegal = illegal_q;
    assign bus.busy = state_q == MUL || state_q == CPY_RD || state_q == CPY_WR;

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        len_d = len_q;
        word_d = word_q;
        valid_d = valid_q;
        last_d = last_q;
        illegal_d = illegal_q;
        if (!bus.stall) begin
            state_d = IDLE;
            idx_d = '0;
            word_d = 16'h0;
            valid_d = 1'b0;
            last_d = 1'b0;
            illegal_d = 1'b0;
            case (state_q)
                MUL: if (idx_q != MUL_LAST) begin
                    state_d = MUL;
                    idx_d = idx_q + ONE;
                    valid_d = 1'b1;
                    last_d = idx_d == MUL_LAST;
                    word_d = last_d ? 16'h8160 : 16'h0160;
                end
                CPY_RD: begin
                    state_d = CPY_WR;
                    idx_d = idx_q;
                    valid_d = 1'b1;
                    word_d = 16'h4803;
                    last_d = idx_q == len_q - ONE;
                end
                CPY_WR: if (idx_q != len_q - ONE) begin
                    state_d = CPY_RD;
                    idx_d = idx_q + ONE;
                    valid_d = 1'b1;
                    word_d = 16'h5003;
                end
                default: if (accept) begin
                    valid_d = 1'b1;
                    if (bus.opcode == MUL_OP) begin
                        state_d = MUL;
                        last_d = MUL_LAST == '0;
                        word_d = last_d ? 16'h8160 : 16'h0160;
                    end else if (bus.opcode == CPY_OP && bus.copy_len != '0) begin
                        state_d = CPY_RD;
                        len_d = bus.copy_len;
                        word_d = 16'h5003;
                    end else begin
                        state_d = ISSUE;
                        last_d = 1'b1;
                        word_d = bus.opcode == CPY_OP ? 16'h0 : dec;
`ifdef ILLEGAL_TRAP_EN
                        illegal_d = bus.opcode != CPY_OP && dec == 16'h0;
                        state_d = illegal_d ? TRAP : ISSUE;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            len_q <= '0;
            word_q <= 16'h0;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            len_q <= len_d;
            word_q <= word_d;
            valid_q <= valid_d;
            last_q <= last_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: decode vectors, directed routine/stall/reset sequences and a randomized run
// checked against a queue-of-expected-words reference model.
`timescale 1ns/1ps
module tb_micro_sequencer;
    localparam int MUL_CYCLES = 4;
    localparam logic [6:0] MUL_OP = 7'b0111111;
    localparam logic [6:0] CPY_OP = 7'b1111111;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic v;
        logic [15:0] w;
        logic l;
        logic [7:0] ix;
        logic b;
        logic il;
        logic rdy;
    } out_t;
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [15:0] w;
        logic ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    vec_t vecs[$];
    out_t q[$];
    out_t cur, idle_o;
    logic [6:0] r_op, r_f7;
    logic [2:0] r_f3;
    logic [7:0] r_len;
    int sel;

    micro_sequencer_if bus();
    micro_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic chk_out(input string n, input out_t e);
        chk(n, {4'b0, bus.ctrl_valid, bus.ctrl_word, bus.uop_last, bus.uop_index, bus.busy, bus.illegal},
               {4'b0, e.v, e.w, e.l, e.ix, e.b, e.il});
    endtask

    function automatic out_t mk(input logic v, input logic [15:0] w, input logic l, input logic [7:0] ix,
                                input logic b, input logic il, input logic rdy);
        return {v, w, l, ix, b, il, rdy};
    endfunction

    task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [15:0] w,
                       input logic ill);
        vec_t t;
        t.op = op; t.f3 = f3; t.f7 = f7; t.w = w; t.ill = ill;
        vecs.push_back(t);
    endtask

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [7:0] len);
        bus.in_valid = v; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7; bus.copy_len = len;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Standard ALU code for the base (funct7=0) operation of each funct3.
    function automatic int alu_of(input logic [2:0] f3);
        case (f3)
            3'd0: return 0;
            3'd1: return 2;
            3'd2: return 3;
            3'd3: return 4;
            3'd4: return 5;
            3'd5: return 6;
            3'd6: return 8;
            default: return 9;
        endcase
    endfunction

    function automatic logic [15:0] ref_word(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int a;
        a = alu_of(f3);
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00) return 16'(32'h8000 + a * 32);
                if (f7 == 7'h20 && f3 == 3'd0) return 16'h8020;
                if (f7 == 7'h20 && f3 == 3'd5) return 16'h80E0;
                return 16'h0;
            end
            7'b0010011: begin
                if (f3 != 3'd5) return 16'(32'hC000 + a * 32);
                if (f7 == 7'h00) return 16'hC0C0;
                if (f7 == 7'h20) return 16'hC0E0;
                return 16'h0;
            end
            7'b1100111: return f3 == 3'd0 ? 16'hC400 : 16'h0;
            7'b0000011: case (f3)
                3'd0: return 16'hF001;
                3'd1: return 16'hF002;
                3'd2: return 16'hF003;
                3'd4: return 16'hF004;
                3'd5: return 16'hF005;
                default: return 16'h0;
            endcase
            7'b0100011: case (f3)
                3'd0: return 16'h4801;
                3'd1: return 16'h4802;
                3'd2: return 16'h4803;
                default: return 16'h0;
            endcase
            7'b1100011: case (f3)
                3'd0: return 16'h0220;
                3'd1: return 16'h0228;
                3'd4: return 16'h0270;
                3'd5: return 16'h0278;
                3'd6: return 16'h0290;
                3'd7: return 16'h0298;
                default: return 16'h0;
            endcase
            default: return 16'h0;
        endcase
    endfunction

    // Expected output stream of one accepted instruction; rdy says whether a new accept is legal while it shows.
    task automatic push_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [7:0] len);
        logic [15:0] w;
        logic ill;
        if (op == MUL_OP) begin
            for (int k = 0; k < MUL_CYCLES; k++)
                q.push_back(mk(1, k == MUL_CYCLES - 1 ? 16'h8160 : 16'h0160, k == MUL_CYCLES - 1, 8'(k), 1, 0, 0));
        end else if (op == CPY_OP && len != 0) begin
            for (int k = 0; k < 2 * int'(len); k++)
                q.push_back(mk(1, k % 2 == 1 ? 16'h4803 : 16'h5003, k == 2 * int'(len) - 1, 8'(k / 2), 1, 0, 0));
        end else begin
            w = op == CPY_OP ? 16'h0 : ref_word(op, f3, f7);
            ill = TRAP && op != CPY_OP && w == 16'h0;
            q.push_back(mk(1, w, 1, 0, 0, ill, !ill));
        end
    endtask

    task automatic run_copy(input logic [7:0] len);
        int n;
        n = 2 * int'(len);
        set_in(1, CPY_OP, 3'd0, 7'h0, len);
        tick();
        set_in(0, 7'h0, 3'd0, 7'h0, 8'd0);
        if (len == 0) begin
            chk_out("cpy_len0", mk(1, 16'h0, 1, 0, 0, 0, 0));
            tick();
        end
        for (int k = 0; k < n; k++) begin
            chk_out($sformatf("cpy%0d_w%0d", len, k), mk(1, k % 2 == 1 ? 16'h4803 : 16'h5003, k == n - 1, 8'(k / 2), 1, 0, 0));
            chk("cpy_rdy", {31'b0, bus.in_ready}, 0);
            tick();
        end
        chk_out($sformatf("cpy%0d_end", len), idle_o);
    endtask

    initial begin
        idle_o = mk(0, 16'h0, 0, 8'h0, 0, 0, 1);
        bus.stall = 1'b0;
        set_in(0, 7'h0, 3'd0, 7'h0, 8'd0);
        add(7'b0110011, 3'd0, 7'h00, 16'h8000, 0);
        add(7'b0110011, 3'd0, 7'h20, 16'h8020, 0);
        add(7'b0000011, 3'd2, 7'h00, 16'hF003, 0);
        add(7'b0100011, 3'd2, 7'h00, 16'h4803, 0);
        add(7'b1100011, 3'd0, 7'h00, 16'h0220, 0);
        add(7'b0110011, 3'd5, 7'h20, 16'h80E0, 0);
        add(7'b0110011, 3'd7, 7'h00, 16'h8120, 0);
        add(7'b0010011, 3'd5, 7'h20, 16'hC0E0, 0);
        add(7'b0010011, 3'd5, 7'h00, 16'hC0C0, 0);
        add(7'b0010011, 3'd4, 7'h55, 16'hC0A0, 0);
        add(7'b1100111, 3'd0, 7'h00, 16'hC400, 0);
        add(7'b0000011, 3'd5, 7'h00, 16'hF005, 0);
        add(7'b0100011, 3'd0, 7'h00, 16'h4801, 0);
        add(7'b1100011, 3'd7, 7'h00, 16'h0298, 0);
        add(7'b1100011, 3'd4, 7'h00, 16'h0270, 0);
        add(7'b0110011, 3'd0, 7'h01, 16'h0000, 1);
        add(7'b0110111, 3'd0, 7'h00, 16'h0000, 1);
        add(7'b0010011, 3'd5, 7'h10, 16'h0000, 1);
        add(7'b1100011, 3'd2, 7'h00, 16'h0000, 1);

        #12;
        chk_out("reset", idle_o);
        chk("reset_rdy", {31'b0, bus.in_ready}, 1);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            set_in(1, vecs[i].op, vecs[i].f3, vecs[i].f7, 8'd0);
            #1 chk($sformatf("vec%0d_rdy", i), {31'b0, bus.in_ready}, 1);
            tick();
            chk_out($sformatf("vec%0d", i), mk(1, vecs[i].w, 1, 0, 0, TRAP && vecs[i].ill, 0));
            if (vecs[i].ill) begin
                set_in(0, 7'h0, 3'd0, 7'h0, 8'd0);
                #1 chk($sformatf("vec%0d_trap_rdy", i), {31'b0, bus.in_ready}, {31'b0, !TRAP});
                tick();
                chk_out($sformatf("vec%0d_after", i), idle_o);
            end
        end
        set_in(0, 7'h0, 3'd0, 7'h0, 8'd0);
        tick();
        chk_out("stream_idle", idle_o);

        // MUL with a pending ADD held on the bus; 3-cycle stall on step 1.
        set_in(1, MUL_OP, 3'd0, 7'h0, 8'd0);
        tick();
        set_in(1, 7'b0110011, 3'd0, 7'h00, 8'd0);
        for (int k = 0; k < MUL_CYCLES; k++) begin
            chk_out($sformatf("mul%0d", k), mk(1, k == MUL_CYCLES - 1 ? 16'h8160 : 16'h0160, k == MUL_CYCLES - 1, 8'(k), 1, 0, 0));
            chk($sformatf("mul%0d_rdy", k), {31'b0, bus.in_ready}, 0);
            if (k == 1) begin
                bus.stall = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk_out("mul_stall_hold", mk(1, 16'h0160, 0, 8'd1, 1, 0, 0));
                    chk("mul_stall_rdy", {31'b0, bus.in_ready}, 0);
                end
                bus.stall = 1'b0;
            end
            tick();
        end
        chk_out("mul_bubble", idle_o);
        chk("mul_bubble_rdy", {31'b0, bus.in_ready}, 1);
        tick();
        chk_out("add_after_mul", mk(1, 16'h8000, 1, 0, 0, 0, 0));
        set_in(0, 7'h0, 3'd0, 7'h0, 8'd0);
        tick();

        run_copy(8'd3);
        run_copy(8'd0);
        run_copy(8'd255);

        // Asynchronous reset while MUL shows step 2.
        set_in(1, MUL_OP, 3'd0, 7'h0, 8'd0);
        tick();
        set_in(0, 7'h0, 3'd0, 7'h0, 8'd0);
        tick();
        tick();
        chk_out("mul_step2", mk(1, 16'h0160, 0, 8'd2, 1, 0, 0));
        #2 rst = 1'b1;
        #1 chk_out("reset_mid_mul", idle_o);
        #2 rst = 1'b0;
        set_in(1, 7'b0110011, 3'd0, 7'h00, 8'd0);
        tick();
        chk_out("add_after_reset", mk(1, 16'h8000, 1, 0, 0, 0, 0));

        rst = 1'b1;
        #2 rst = 1'b0;
        cur = idle_o;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            sel = int'($urandom_range(0, 9));
            r_op = sel == 0 ? 7'b0110011 : sel == 1 ? 7'b0010011 : sel == 2 ? 7'b0000011 :
                   sel == 3 ? 7'b0100011 : sel == 4 ? 7'b1100011 : sel == 5 ? 7'b1100111 :
                   sel == 6 ? MUL_OP : sel == 7 ? CPY_OP : 7'($urandom);
            r_f3 = 3'($urandom);
            sel = int'($urandom_range(0, 2));
            r_f7 = sel == 0 ? 7'h00 : sel == 1 ? 7'h20 : 7'($urandom);
            r_len = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom_range(1, 6));
            set_in($urandom_range(0, 2) != 0, r_op, r_f3, r_f7, r_len);
            bus.stall = $urandom_range(0, 4) == 0;
            #1 chk("rnd_rdy", {31'b0, bus.in_ready}, {31'b0, !bus.stall && cur.rdy});
            if (!bus.stall) begin
                if (bus.in_valid && cur.rdy) push_instr(r_op, r_f3, r_f7, r_len);
                cur = q.size() != 0 ? q.pop_front() : idle_o;
            end
            tick();
            chk_out($sformatf("rnd%0d", c), cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
